pre_if_pc_reg: RTL and testbench
================================

Name: pre_if_pc_reg

Overview:
- Program-counter register for the PRE_IF stage.
- Consumes the 3-bit next-PC select code plus candidate targets and produces the fetch PC presented to IF.
- Supports IF back-pressure. A redirect that arrives while IF is stalled is buffered and applied when IF accepts, so no redirect is lost.
- Resolves priority between pending and new redirects.

Parameters:
- RESET_PC, 32'hBFC0_0000, PC value loaded on reset.
- PC_W, 32, PC/target width.

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous active-low reset
- PCSel  in  3  next-PC select: 000 PC4, 001 ImmeJump, 010 EPC, 011 Except, 100 Branch, 101 JR, 110 MEMPC, 111 illegal
- ImmeJump_Target  in  PC_W  J/JAL target
- Branch_Target  in  PC_W  conditional-branch target
- JR_Target  in  PC_W  register-jump target
- EPC_Target  in  PC_W  CP0 EPC (ERET)
- Except_Target  in  PC_W  exception vector
- MEMPC_Target  in  PC_W  refetch PC from MEM
- IF_Ready  in  1  IF accepts PC this cycle
- PC_o  out  PC_W  current fetch PC
- PC_Valid  out  1  PC_o is a valid fetch request
- Redirect_Pending  out  1  buffered redirect waiting

Behaviour:
- Classes:
  - Class A (EPC, Except, MEMPC) comes from older instructions.
  - Class B (ImmeJump, Branch, JR) comes from EX.
  - PC4 means no redirect. Illegal 111 is treated as PC4.
- Async reset (resetn low, any time, including mid-stall):
  - PC_o=RESET_PC, PC_Valid=0, Redirect_Pending=0.
  - pend_target=0, pend_class=none.
  - FSM enters S_BOOT.
- FSM states:
  - S_BOOT: one cycle after reset release. PC_Valid goes 1 at the next edge and the FSM moves to S_RUN. PC_o is unchanged. Inputs are ignored.
  - S_RUN: no pending redirect.
  - S_HOLD: redirect buffered; Redirect_Pending=1.
- Target mux (combinational): sel_target = target chosen by PCSel; seq = PC_o+4, wrapping modulo 2^PC_W.
- S_RUN:
  - IF_Ready=1, PCSel=PC4: PC_o<=seq.
  - IF_Ready=1, redirect: PC_o<=sel_target. Applied the same edge; 1-cycle redirect latency.
  - IF_Ready=0, PC4: hold PC_o.
  - IF_Ready=0, redirect: hold PC_o, pend_target<=sel_target, pend_class<=class, go S_HOLD.
- S_HOLD:
  - New redirect replaces the pending one if new class is A, or if both are B. A new B never replaces a pending A. PC4 never replaces.
  - IF_Ready=1 with a new redirect: the winner is written to PC_o directly, pending is cleared, go S_RUN.
  - IF_Ready=1 without a new redirect: PC_o<=pend_target, pending is cleared, go S_RUN.
  - IF_Ready=0: stay in S_HOLD with the updated buffer.
- PC_Valid stays 1 from S_RUN onward. The PC is never dropped; IF stall only freezes PC_o.
- PC_o always changes only on a clk edge and is registered; no combinational path from PCSel to PC_o.
- Redirect_Pending is registered and equals (state==S_HOLD).
- Simulation assertions: PCSel is never X once PC_Valid=1; PCSel=111 flags an error.

Test Plan:
- Reset then release, IF_Ready=1, PCSel=000 for 4 cycles -> PC_Valid rises 1 cycle after release; PC_o = BFC00000, BFC00004, BFC00008, BFC0000C.
- PC_o=BFC00010, IF_Ready=1, PCSel=100, Branch_Target=BFC00100 -> next cycle PC_o=BFC00100, Redirect_Pending=0.
- IF_Ready=0, PCSel=101 JR_Target=80001000 for 1 cycle, then PC4 for 3 stalled cycles, then IF_Ready=1 -> Redirect_Pending=1 during stall; PC_o held; PC_o=80001000 after release.
- IF_Ready=0: PCSel=011 Except_Target=BFC00380, next cycle PCSel=001 ImmeJump_Target=BFC00200, then IF_Ready=1 -> PC_o=BFC00380 (B does not override pending A).
- IF_Ready=0: PCSel=100 Branch_Target=A0000040, next cycle PCSel=110 MEMPC_Target=A0000020 with IF_Ready=1 -> PC_o=A0000020 the same edge.
- PC_o=FFFFFFFC, PC4, IF_Ready=1 -> PC_o=00000000. Assert resetn low while S_HOLD -> PC_o=BFC00000, Redirect_Pending=0 immediately.

Source files
------------

// File: rtl/pre_if_pc_reg.sv
// Fetch PC register for PRE_IF: selects next PC from the 3-bit select code and holds it under IF back-pressure.
// Latency: a redirect applied while IF is ready shows on PC_o after one edge; a buffered one on the edge IF accepts.
// Back-pressure: IF_Ready=0 freezes PC_o; a redirect arriving during the stall is buffered (A beats B) and never lost.
module pre_if_pc_reg #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int          PC_W     = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [2:0]      PCSel,
  input  logic [PC_W-1:0] ImmeJump_Target,
  input  logic [PC_W-1:0] Branch_Target,
  input  logic [PC_W-1:0] JR_Target,
  input  logic [PC_W-1:0] EPC_Target,
  input  logic [PC_W-1:0] Except_Target,
  input  logic [PC_W-1:0] MEMPC_Target,
  input  logic            IF_Ready,
  output logic [PC_W-1:0] PC_o,
  output logic            PC_Valid,
  output logic            Redirect_Pending
);

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  // Redirect classes: A comes from older instructions and outranks B from EX.
  localparam logic [1:0] C_NONE = 2'd0;
  localparam logic [1:0] C_A    = 2'd1;
  localparam logic [1:0] C_B    = 2'd2;

  logic [1:0]      r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_valid;
  logic            r_pending;
  logic [PC_W-1:0] r_pend_target;
  logic [1:0]      r_pend_class;

  logic [PC_W-1:0] w_sel_target;
  logic [1:0]      w_sel_class;
  logic [PC_W-1:0] w_seq;
  logic            w_new_wins;
  logic [PC_W-1:0] w_win_target;
  logic [1:0]      w_win_class;
  logic [1:0]      w_state_nxt;
  logic [PC_W-1:0] w_pc_nxt;
  logic [PC_W-1:0] w_pend_target_nxt;
  logic [1:0]      w_pend_class_nxt;

  // Decode the select code into a candidate target and its class; 111 behaves as PC4.
  always_comb begin
    w_sel_target = '0;
    w_sel_class  = C_NONE;
    case (PCSel)
      3'b001:  begin w_sel_target = ImmeJump_Target; w_sel_class = C_B; end
      3'b010:  begin w_sel_target = EPC_Target;      w_sel_class = C_A; end
      3'b011:  begin w_sel_target = Except_Target;   w_sel_class = C_A; end
      3'b100:  begin w_sel_target = Branch_Target;   w_sel_class = C_B; end
      3'b101:  begin w_sel_target = JR_Target;       w_sel_class = C_B; end
      3'b110:  begin w_sel_target = MEMPC_Target;    w_sel_class = C_A; end
      default: begin w_sel_target = '0;              w_sel_class = C_NONE; end
    endcase
  end

  assign w_seq = r_pc + PC_W'(4);

  // A new A always wins; a new B wins only over a pending B; PC4 never displaces a pending redirect.
  assign w_new_wins   = (w_sel_class == C_A) || ((w_sel_class == C_B) && (r_pend_class == C_B));
  assign w_win_target = w_new_wins ? w_sel_target : r_pend_target;
  assign w_win_class  = w_new_wins ? w_sel_class  : r_pend_class;

  // Next-state, next-PC and pending-buffer update.
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_pend_target_nxt = r_pend_target;
    w_pend_class_nxt  = r_pend_class;
    case (r_state)
      S_BOOT: begin
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (IF_Ready) begin
          w_pc_nxt = (w_sel_class == C_NONE) ? w_seq : w_sel_target;
        end else if (w_sel_class != C_NONE) begin
          w_pend_target_nxt = w_sel_target;
          w_pend_class_nxt  = w_sel_class;
          w_state_nxt       = S_HOLD;
        end
      end
      S_HOLD: begin
        if (IF_Ready) begin
          w_pc_nxt          = w_win_target;
          w_pend_target_nxt = '0;
          w_pend_class_nxt  = C_NONE;
          w_state_nxt       = S_RUN;
        end else begin
          w_pend_target_nxt = w_win_target;
          w_pend_class_nxt  = w_win_class;
        end
      end
      default: begin
        w_state_nxt = S_BOOT;
      end
    endcase
  end

  // State registers; reset may land at any time, including mid-stall.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_BOOT;
      r_pc          <= RESET_PC[PC_W-1:0];
      r_valid       <= 1'b0;
      r_pending     <= 1'b0;
      r_pend_target <= '0;
      r_pend_class  <= C_NONE;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_valid       <= r_valid | (r_state == S_BOOT);
      r_pending     <= (w_state_nxt == S_HOLD);
      r_pend_target <= w_pend_target_nxt;
      r_pend_class  <= w_pend_class_nxt;
    end
  end

  assign PC_o             = r_pc;
  assign PC_Valid         = r_valid;
  assign Redirect_Pending = r_pending;

  // Once fetching, the select code must be known and never the illegal 111 encoding.
  a_pcsel_known: assert property (@(posedge clk) disable iff (!resetn)
    r_valid |-> !$isunknown(PCSel));
  a_pcsel_legal: assert property (@(posedge clk) disable iff (!resetn)
    r_valid |-> (PCSel != 3'b111));

endmodule

// File: tb/tb_pre_if_pc_reg.sv
module tb_pre_if_pc_reg;

  typedef struct packed {
    logic        ready;
    logic [2:0]  sel;
    logic [31:0] tgt;
  } stim_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        vld;
    logic        pend;
  } exp_t;

  logic        clk;
  logic        resetn;
  logic [2:0]  PCSel;
  logic [31:0] ImmeJump_Target, Branch_Target, JR_Target;
  logic [31:0] EPC_Target, Except_Target, MEMPC_Target;
  logic        IF_Ready;
  logic [31:0] PC_o;
  logic        PC_Valid;
  logic        Redirect_Pending;

  int   checks;
  int   failures;
  exp_t sb[$];
  exp_t e;

  pre_if_pc_reg #(.RESET_PC(32'hBFC0_0000), .PC_W(32)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .PCSel            (PCSel),
    .ImmeJump_Target  (ImmeJump_Target),
    .Branch_Target    (Branch_Target),
    .JR_Target        (JR_Target),
    .EPC_Target       (EPC_Target),
    .Except_Target    (Except_Target),
    .MEMPC_Target     (MEMPC_Target),
    .IF_Ready         (IF_Ready),
    .PC_o             (PC_o),
    .PC_Valid         (PC_Valid),
    .Redirect_Pending (Redirect_Pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Selected port carries tgt; every other target port carries a distinct decoy.
  task automatic apply(input stim_t s);
    IF_Ready        = s.ready;
    PCSel           = s.sel;
    ImmeJump_Target = (s.sel == 3'b001) ? s.tgt : 32'h1111_1110;
    EPC_Target      = (s.sel == 3'b010) ? s.tgt : 32'h2222_2220;
    Except_Target   = (s.sel == 3'b011) ? s.tgt : 32'h3333_3330;
    Branch_Target   = (s.sel == 3'b100) ? s.tgt : 32'h4444_4440;
    JR_Target       = (s.sel == 3'b101) ? s.tgt : 32'h5555_5550;
    MEMPC_Target    = (s.sel == 3'b110) ? s.tgt : 32'h6666_6660;
  endtask

  task automatic test_reset();
    stim_t st [5] = '{'{1'b1, 3'b101, 32'h8000_0000}, '{1'b1, 3'b000, 32'h0},
                      '{1'b1, 3'b000, 32'h0},          '{1'b1, 3'b000, 32'h0},
                      '{1'b1, 3'b000, 32'h0}};
    exp_t ex [5] = '{'{32'hBFC0_0000, 1'b1, 1'b0}, '{32'hBFC0_0004, 1'b1, 1'b0},
                     '{32'hBFC0_0008, 1'b1, 1'b0}, '{32'hBFC0_000C, 1'b1, 1'b0},
                     '{32'hBFC0_0010, 1'b1, 1'b0}};
    resetn = 1'b0;
    apply('{1'b1, 3'b000, 32'h0});
    #12;
    checks++;
    if ({PC_o, PC_Valid, Redirect_Pending} !== {32'hBFC0_0000, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: got pc=%h vld=%b pend=%b want pc=bfc00000 vld=0 pend=0",
               PC_o, PC_Valid, Redirect_Pending);
    end
    @(negedge clk);
    resetn = 1'b1;
    foreach (st[i]) begin
      apply(st[i]); sb.push_back(ex[i]);
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if ({PC_o, PC_Valid, Redirect_Pending} !== e) begin
        failures++;
        $display("FAIL boot_seq[%0d]: got pc=%h vld=%b pend=%b want pc=%h vld=%b pend=%b",
                 i, PC_o, PC_Valid, Redirect_Pending, e.pc, e.vld, e.pend);
      end
    end
  endtask

  task automatic test_branch();
    stim_t st [3] = '{'{1'b1, 3'b100, 32'hBFC0_0100}, '{1'b1, 3'b000, 32'h0},
                      '{1'b0, 3'b000, 32'h0}};
    exp_t ex [3] = '{'{32'hBFC0_0100, 1'b1, 1'b0}, '{32'hBFC0_0104, 1'b1, 1'b0},
                     '{32'hBFC0_0104, 1'b1, 1'b0}};
    foreach (st[i]) begin
      apply(st[i]); sb.push_back(ex[i]);
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if ({PC_o, PC_Valid, Redirect_Pending} !== e) begin
        failures++;
        $display("FAIL branch[%0d]: got pc=%h vld=%b pend=%b want pc=%h vld=%b pend=%b",
                 i, PC_o, PC_Valid, Redirect_Pending, e.pc, e.vld, e.pend);
      end
    end
  endtask

  task automatic test_stall_jr();
    stim_t st [6] = '{'{1'b0, 3'b101, 32'h8000_1000}, '{1'b0, 3'b000, 32'h0},
                      '{1'b0, 3'b000, 32'h0},          '{1'b0, 3'b000, 32'h0},
                      '{1'b1, 3'b000, 32'h0},          '{1'b1, 3'b000, 32'h0}};
    exp_t ex [6] = '{'{32'hBFC0_0104, 1'b1, 1'b1}, '{32'hBFC0_0104, 1'b1, 1'b1},
                     '{32'hBFC0_0104, 1'b1, 1'b1}, '{32'hBFC0_0104, 1'b1, 1'b1},
                     '{32'h8000_1000, 1'b1, 1'b0}, '{32'h8000_1004, 1'b1, 1'b0}};
    foreach (st[i]) begin
      apply(st[i]); sb.push_back(ex[i]);
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if ({PC_o, PC_Valid, Redirect_Pending} !== e) begin
        failures++;
        $display("FAIL stall_jr[%0d]: got pc=%h vld=%b pend=%b want pc=%h vld=%b pend=%b",
                 i, PC_o, PC_Valid, Redirect_Pending, e.pc, e.vld, e.pend);
      end
    end
  endtask

  task automatic test_a_over_b();
    stim_t st [5] = '{'{1'b0, 3'b011, 32'hBFC0_0380}, '{1'b0, 3'b001, 32'hBFC0_0200},
                      '{1'b1, 3'b000, 32'h0},
                      '{1'b0, 3'b010, 32'hBFC0_0180}, '{1'b1, 3'b101, 32'h1234_5678}};
    exp_t ex [5] = '{'{32'h8000_1004, 1'b1, 1'b1}, '{32'h8000_1004, 1'b1, 1'b1},
                     '{32'hBFC0_0380, 1'b1, 1'b0},
                     '{32'hBFC0_0380, 1'b1, 1'b1}, '{32'hBFC0_0180, 1'b1, 1'b0}};
    foreach (st[i]) begin
      apply(st[i]); sb.push_back(ex[i]);
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if ({PC_o, PC_Valid, Redirect_Pending} !== e) begin
        failures++;
        $display("FAIL a_over_b[%0d]: got pc=%h vld=%b pend=%b want pc=%h vld=%b pend=%b",
                 i, PC_o, PC_Valid, Redirect_Pending, e.pc, e.vld, e.pend);
      end
    end
  endtask

  task automatic test_replace();
    stim_t st [10] = '{'{1'b0, 3'b100, 32'hA000_0040}, '{1'b1, 3'b110, 32'hA000_0020},
                       '{1'b0, 3'b100, 32'hA000_0100}, '{1'b0, 3'b101, 32'hA000_0200},
                       '{1'b1, 3'b000, 32'h0},
                       '{1'b0, 3'b011, 32'hB000_0000}, '{1'b0, 3'b010, 32'hB000_0100},
                       '{1'b1, 3'b000, 32'h0},
                       '{1'b0, 3'b100, 32'hC000_0000}, '{1'b1, 3'b001, 32'hC000_0100}};
    exp_t ex [10] = '{'{32'hBFC0_0180, 1'b1, 1'b1}, '{32'hA000_0020, 1'b1, 1'b0},
                      '{32'hA000_0020, 1'b1, 1'b1}, '{32'hA000_0020, 1'b1, 1'b1},
                      '{32'hA000_0200, 1'b1, 1'b0},
                      '{32'hA000_0200, 1'b1, 1'b1}, '{32'hA000_0200, 1'b1, 1'b1},
                      '{32'hB000_0100, 1'b1, 1'b0},
                      '{32'hB000_0100, 1'b1, 1'b1}, '{32'hC000_0100, 1'b1, 1'b0}};
    foreach (st[i]) begin
      apply(st[i]); sb.push_back(ex[i]);
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if ({PC_o, PC_Valid, Redirect_Pending} !== e) begin
        failures++;
        $display("FAIL replace[%0d]: got pc=%h vld=%b pend=%b want pc=%h vld=%b pend=%b",
                 i, PC_o, PC_Valid, Redirect_Pending, e.pc, e.vld, e.pend);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t st [4] = '{'{1'b1, 3'b101, 32'h0000_1000}, '{1'b1, 3'b100, 32'h0000_2000},
                      '{1'b1, 3'b010, 32'h0000_3000}, '{1'b1, 3'b000, 32'h0}};
    exp_t ex [4] = '{'{32'h0000_1000, 1'b1, 1'b0}, '{32'h0000_2000, 1'b1, 1'b0},
                     '{32'h0000_3000, 1'b1, 1'b0}, '{32'h0000_3004, 1'b1, 1'b0}};
    foreach (st[i]) begin
      apply(st[i]); sb.push_back(ex[i]);
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if ({PC_o, PC_Valid, Redirect_Pending} !== e) begin
        failures++;
        $display("FAIL back_to_back[%0d]: got pc=%h vld=%b pend=%b want pc=%h vld=%b pend=%b",
                 i, PC_o, PC_Valid, Redirect_Pending, e.pc, e.vld, e.pend);
      end
    end
  endtask

  task automatic test_wrap();
    stim_t st [3] = '{'{1'b1, 3'b101, 32'hFFFF_FFFC}, '{1'b1, 3'b000, 32'h0},
                      '{1'b1, 3'b000, 32'h0}};
    exp_t ex [3] = '{'{32'hFFFF_FFFC, 1'b1, 1'b0}, '{32'h0000_0000, 1'b1, 1'b0},
                     '{32'h0000_0004, 1'b1, 1'b0}};
    foreach (st[i]) begin
      apply(st[i]); sb.push_back(ex[i]);
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if ({PC_o, PC_Valid, Redirect_Pending} !== e) begin
        failures++;
        $display("FAIL wrap[%0d]: got pc=%h vld=%b pend=%b want pc=%h vld=%b pend=%b",
                 i, PC_o, PC_Valid, Redirect_Pending, e.pc, e.vld, e.pend);
      end
    end
  endtask

  task automatic test_reset_in_hold();
    stim_t st [3] = '{'{1'b1, 3'b101, 32'h7000_0000}, '{1'b1, 3'b000, 32'h0},
                      '{1'b0, 3'b000, 32'h0}};
    exp_t ex [3] = '{'{32'hBFC0_0000, 1'b1, 1'b0}, '{32'hBFC0_0004, 1'b1, 1'b0},
                     '{32'hBFC0_0004, 1'b1, 1'b0}};
    apply('{1'b0, 3'b100, 32'hA000_0040});
    sb.push_back('{32'h0000_0004, 1'b1, 1'b1});
    @(posedge clk); #1;
    e = sb.pop_front(); checks++;
    if ({PC_o, PC_Valid, Redirect_Pending} !== e) begin
      failures++;
      $display("FAIL hold_before_reset: got pc=%h vld=%b pend=%b want pc=%h vld=%b pend=%b",
               PC_o, PC_Valid, Redirect_Pending, e.pc, e.vld, e.pend);
    end
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if ({PC_o, PC_Valid, Redirect_Pending} !== {32'hBFC0_0000, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset_in_hold: got pc=%h vld=%b pend=%b want pc=bfc00000 vld=0 pend=0",
               PC_o, PC_Valid, Redirect_Pending);
    end
    @(negedge clk);
    resetn = 1'b1;
    foreach (st[i]) begin
      apply(st[i]); sb.push_back(ex[i]);
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if ({PC_o, PC_Valid, Redirect_Pending} !== e) begin
        failures++;
        $display("FAIL after_reset[%0d]: got pc=%h vld=%b pend=%b want pc=%h vld=%b pend=%b",
                 i, PC_o, PC_Valid, Redirect_Pending, e.pc, e.vld, e.pend);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_branch();
    test_stall_jr();
    test_a_over_b();
    test_replace();
    test_back_to_back();
    test_wrap();
    test_reset_in_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
